image_framer: RTL and testbench

- Upstream feeder for the perceptron classifier.
- Accepts a 5x5 binary image one row per beat over a valid/ready stream and assembles it into the 25-bit image vector.
- Drives the perceptron's `in`/`en` pair and waits for its `ready`, then returns the class and accumulator to the consumer through a result valid/ready handshake.
- Adds a timeout so that a stalled perceptron cannot hang the pipeline.

---
 rtl/gusn_pkg.sv | 8 +
 rtl/image_framer.sv | 115 +++++++++++
 tb/tb_image_framer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gusn_pkg.sv
// gusn_pkg: shared FSM states, class codes and image geometry for the perceptron front end
package gusn_pkg;
  typedef enum logic [1:0] {LOAD, DRAIN, COMPUTE, RESULT} state_e;
  localparam logic [1:0] CLASS_CIRCLE = 2'd2;
  localparam logic [1:0] CLASS_CROSS = 2'd3;
  localparam int IMG_ROWS = 5;
  localparam int IMG_COLS = 5;
endpackage

// File: rtl/image_framer.sv
// image_framer: assembles streamed rows into an image, runs the perceptron, returns its result
//   row_*   : row stream in (valid/ready, sof resyncs the frame)
//   img_*   : image and enable to the perceptron
//   pcpt_*  : perceptron ready/class/accumulator
//   res_*   : result stream out (valid/ready, err marks a timeout)
module image_framer import gusn_pkg::*; #(
  parameter int ROWS = IMG_ROWS,
  parameter int COLS = IMG_COLS,
  parameter int TIMEOUT = 255,
  localparam int WIDTH = ROWS * COLS,
  localparam int ACC_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COLS-1:0]  row_in,
  input  logic             row_sof,
  input  logic             row_valid,
  output logic             row_ready,
  output logic [WIDTH-1:0] img_out,
  output logic             img_en,
  input  logic             pcpt_ready,
  input  logic [1:0]       pcpt_out,
  input  logic [ACC_W-1:0] pcpt_acc,
  output logic [1:0]       res_class,
  output logic [ACC_W-1:0] res_acc,
  output logic             res_err,
  output logic             res_valid,
  input  logic             res_ready
);
  localparam int CW = $clog2(ROWS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0] cls_q, cls_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic err_q, err_d;
  logic row_ready_q, img_en_q, res_valid_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    frame_d = frame_q;
    tmo_d = tmo_q;
    cls_d = cls_q;
    acc_d = acc_q;
    err_d = err_q;
    case (state_q)
      LOAD: if (row_valid && row_ready_q) begin
        frame_d = row_sof ? WIDTH'(row_in) : {frame_q[WIDTH-COLS-1:0], row_in};
        cnt_d = row_sof ? CW'(1) : cnt_q + CW'(1);
        if (cnt_d == ROWS_C) state_d = DRAIN;
      end
      // wait for the perceptron to drop ready so the next ready belongs to this image
      DRAIN: if (!pcpt_ready) begin
        state_d = COMPUTE;
        tmo_d = '0;
      end
      COMPUTE: begin
        tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TW'(1);
        if (pcpt_ready) begin
          state_d = RESULT;
          cls_d = pcpt_out;
          acc_d = pcpt_acc;
          err_d = 1'b0;
        end else if (tmo_q == TLAST) begin
          state_d = RESULT;
          cls_d = '0;
          acc_d = '0;
          err_d = 1'b1;
        end
      end
      RESULT: if (res_ready) begin
        state_d = LOAD;
        cnt_d = '0;
      end
      default: state_d = LOAD;
    endcase
  end
  // handshake outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q <= '0;
      frame_q <= '0;
      tmo_q <= '0;
      cls_q <= '0;
      acc_q <= '0;
      err_q <= 1'b0;
      row_ready_q <= 1'b0;
      img_en_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      frame_q <= frame_d;
      tmo_q <= tmo_d;
      cls_q <= cls_d;
      acc_q <= acc_d;
      err_q <= err_d;
      row_ready_q <= state_d == LOAD;
      img_en_q <= state_d == COMPUTE;
      res_valid_q <= state_d == RESULT;
    end
  end
  assign row_ready = row_ready_q;
  assign img_out = frame_q;
  assign img_en = img_en_q;
  assign res_class = cls_q;
  assign res_acc = acc_q;
  assign res_err = err_q;
  assign res_valid = res_valid_q;
endmodule

// File: tb/tb_image_framer.sv
// tb_image_framer: directed bench for image_framer with a behavioural perceptron stand-in
module tb_image_framer;
  import gusn_pkg::*;
  localparam logic [24:0] CIRCLE = 25'h0454544;
  localparam logic [24:0] CROSS = 25'h1151151;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] row_in;
  logic row_sof, row_valid, row_ready;
  logic [24:0] img_out;
  logic img_en;
  logic p_ready;
  logic [1:0] p_out;
  logic [4:0] p_acc;
  logic [1:0] res_class;
  logic [4:0] res_acc;
  logic res_err, res_valid, res_ready;
  logic stall;
  int lat;
  int pc;
  int n_asrt = 0;
  int n_fail = 0;
  int n_res = 0;
  always #5 clk = ~clk;
  image_framer dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .row_sof(row_sof), .row_valid(row_valid),
    .row_ready(row_ready), .img_out(img_out), .img_en(img_en), .pcpt_ready(p_ready),
    .pcpt_out(p_out), .pcpt_acc(p_acc), .res_class(res_class), .res_acc(res_acc),
    .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready)
  );
  // perceptron stand-in: ready rises lat+1 cycles into en, drops with en; stall keeps it low
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_ready <= 1'b0;
      p_out <= '0;
      p_acc <= '0;
      pc <= 0;
    end else if (!img_en) begin
      p_ready <= 1'b0;
      pc <= 0;
    end else begin
      pc <= pc + 1;
      if (!stall && pc == lat) begin
        p_ready <= 1'b1;
        p_out <= img_out == CIRCLE ? CLASS_CIRCLE : img_out == CROSS ? CLASS_CROSS : 2'd1;
        p_acc <= img_out == CIRCLE ? 5'd4 : img_out == CROSS ? 5'd11 : 5'd0;
      end
    end
  end
  always @(posedge clk) if (res_valid && res_ready) n_res <= n_res + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_row(input logic [4:0] r, input logic s);
    int n = 0;
    row_in = r;
    row_sof = s;
    row_valid = 1'b1;
    while (!row_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("row_ready_wait", 0, 1);
    @(negedge clk);
    row_valid = 1'b0;
    row_sof = 1'b0;
  endtask
  task automatic send_frame(input logic [24:0] img, input logic sof);
    for (int i = 0; i < 5; i++) send_row(img[24-5*i -: 5], sof && i == 0);
  endtask
  task automatic wait_res(input string tag, output int en_cycles);
    int n = 0;
    en_cycles = 0;
    while (!res_valid && n < 600) begin
      if (img_en) en_cycles++;
      @(negedge clk);
      n++;
    end
    chk(tag, res_valid, 1);
  endtask
  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask
  initial begin
    int ec;
    int base;
    logic bad;
    rst_n = 1'b0;
    row_in = '0;
    row_sof = 1'b0;
    row_valid = 1'b0;
    res_ready = 1'b0;
    stall = 1'b0;
    lat = 2;
    repeat (3) @(negedge clk);
    chk("rst_row_ready", row_ready, 0);
    chk("rst_img_en", img_en, 0);
    chk("rst_img_out", img_out, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_fields", {res_err, res_class, res_acc}, 0);
    rst_n = 1'b1;
    #1 chk("rel_row_ready_low", row_ready, 0);
    @(negedge clk);
    chk("rel_row_ready_high", row_ready, 1);
    send_frame(CIRCLE, 1'b1);
    chk("circle_ready_drops", row_ready, 0);
    chk("circle_en_drain", img_en, 0);
    chk("circle_img", img_out, CIRCLE);
    @(negedge clk);
    chk("circle_en_rise", img_en, 1);
    wait_res("circle_res_valid", ec);
    chk("circle_res", {res_err, res_class, res_acc}, {1'b0, CLASS_CIRCLE, 5'd4});
    handshake();
    chk("circle_hs_valid", res_valid, 0);
    chk("circle_hs_ready", row_ready, 1);
    send_frame(CROSS, 1'b0);
    chk("cross_img", img_out, CROSS);
    wait_res("cross_res_valid", ec);
    chk("cross_res", {res_err, res_class, res_acc}, {1'b0, CLASS_CROSS, 5'd11});
    handshake();
    base = n_res;
    send_row(5'h1F, 1'b1);
    send_row(5'h03, 1'b0);
    send_row(5'h18, 1'b0);
    send_frame(CROSS, 1'b1);
    chk("resync_img", img_out, CROSS);
    wait_res("resync_res_valid", ec);
    chk("resync_class", res_class, CLASS_CROSS);
    handshake();
    repeat (5) @(negedge clk);
    chk("resync_one_result", n_res - base, 1);
    send_frame(CIRCLE, 1'b1);
    wait_res("bp_res_valid", ec);
    row_in = 5'h11;
    row_sof = 1'b1;
    row_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (row_ready || !res_valid || res_class != CLASS_CIRCLE || res_acc != 5'd4 || res_err) bad = 1'b1;
    end
    chk("bp_stable", bad, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_ready_after_hs", row_ready, 1);
    @(negedge clk);
    row_valid = 1'b0;
    row_sof = 1'b0;
    send_row(5'h0A, 1'b0);
    send_row(5'h04, 1'b0);
    send_row(5'h0A, 1'b0);
    send_row(5'h11, 1'b0);
    chk("bp_img_no_loss", img_out, CROSS);
    wait_res("bp2_res_valid", ec);
    chk("bp2_class", res_class, CLASS_CROSS);
    handshake();
    stall = 1'b1;
    send_frame(CIRCLE, 1'b1);
    wait_res("tmo_res_valid", ec);
    chk("tmo_cycles", ec, 255);
    chk("tmo_res", {res_err, res_class, res_acc}, {1'b1, 2'd0, 5'd0});
    handshake();
    stall = 1'b0;
    lat = 253;
    send_frame(CIRCLE, 1'b1);
    wait_res("edge_res_valid", ec);
    chk("edge_cycles", ec, 255);
    chk("edge_res", {res_err, res_class, res_acc}, {1'b0, CLASS_CIRCLE, 5'd4});
    handshake();
    lat = 2;
    stall = 1'b1;
    send_frame(CIRCLE, 1'b1);
    repeat (10) @(negedge clk);
    chk("mid_compute_en", img_en, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_en", img_en, 0);
    chk("arst_valid", res_valid, 0);
    chk("arst_row_ready", row_ready, 0);
    repeat (2) @(negedge clk);
    chk("arst_row_ready_held", row_ready, 0);
    rst_n = 1'b1;
    stall = 1'b0;
    #1 chk("arst_rel_low", row_ready, 0);
    @(negedge clk);
    chk("arst_rel_high", row_ready, 1);
    send_frame(CIRCLE, 1'b1);
    chk("post_rst_img", img_out, CIRCLE);
    wait_res("post_rst_valid", ec);
    chk("post_rst_res", {res_err, res_class, res_acc}, {1'b0, CLASS_CIRCLE, 5'd4});
    handshake();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
